// File: rtl/fifo_buffer_pkg.sv
// fifo_buffer_pkg: shared defaults, baud divisor and FSM encodings for the UART loopback buffer
package fifo_buffer_pkg;
  localparam int CLK_FREQ_DEF = 12_000_000;
  localparam int BAUD_DEF = 9600;
  localparam int DEPTH_DEF = 32;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/fifo_buffer_if.sv
// fifo_buffer_if: serial lines of the loopback buffer (rx in, tx data out, tx2 line echo)
interface fifo_buffer_if;
  logic rx;
  logic tx;
  logic tx2;
  modport master (output rx, input tx, tx2);
  modport slave (input rx, output tx, tx2);
endinterface

// File: rtl/fifo_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead output; pushes while full are dropped unless a pop frees a slot
module sync_fifo
  import fifo_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic wr, rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: 8N1 UART receiver feeding a FIFO that is replayed on tx; tx2 echoes the synchronised rx line
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD = BAUD_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clock,
  input logic reset,
  fifo_buffer_if.slave uart
);
  localparam int C = clks_per_bit(CLK_FREQ, BAUD);
  localparam int H = C / 2;
  localparam int CW = $clog2(C);
  localparam int BW = $clog2(DATA_W);
  logic s1, s2, echo;
  rx_state_t rs, rs_n;
  tx_state_t ts, ts_n;
  logic [CW-1:0] rcnt, rcnt_n, tcnt, tcnt_n;
  logic [BW-1:0] rbit, rbit_n, tbit, tbit_n;
  logic [DATA_W-1:0] rsh, rsh_n, tsh, tsh_n, dout;
  logic ferr, ferr_n, push, push_n, pop, full, empty, txq, txq_n;
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clock), .rst(reset), .push(push), .pop(pop),
    .din(rsh), .dout(dout), .full(full), .empty(empty)
  );
  // echo doubles as the previous synchronised sample for start-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) {s1, s2, echo} <= 3'b111;
    else {s1, s2, echo} <= {uart.rx, s1, s2};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs <= RX_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rsh <= '0;
      ferr <= 1'b0;
      push <= 1'b0;
    end else begin
      rs <= rs_n;
      rcnt <= rcnt_n;
      rbit <= rbit_n;
      rsh <= rsh_n;
      ferr <= ferr_n;
      push <= push_n;
    end
  end
  always_comb begin
    rs_n = rs;
    rcnt_n = rcnt + CW'(1);
    rbit_n = rbit;
    rsh_n = rsh;
    ferr_n = ferr;
    push_n = 1'b0;
    case (rs)
      RX_IDLE: begin
        rcnt_n = '0;
        ferr_n = 1'b0;
        rs_n = (echo & ~s2) ? RX_START : RX_IDLE;
      end
      RX_START: if (rcnt == CW'(H-1)) begin
        rcnt_n = '0;
        rbit_n = '0;
        rs_n = s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rcnt == CW'(C-1)) begin
        rcnt_n = '0;
        rsh_n = {s2, rsh[DATA_W-1:1]};
        rbit_n = rbit + BW'(1);
        rs_n = (rbit == BW'(DATA_W-1)) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (ferr) begin
        rcnt_n = '0;
        rs_n = s2 ? RX_IDLE : RX_STOP;
      end else if (rcnt == CW'(C-1)) begin
        rcnt_n = '0;
        push_n = s2 & ~full;
        ferr_n = ~s2;
        rs_n = s2 ? RX_IDLE : RX_STOP;
      end
      default: rs_n = RX_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts <= TX_IDLE;
      tcnt <= '0;
      tbit <= '0;
      tsh <= '0;
      txq <= 1'b1;
    end else begin
      ts <= ts_n;
      tcnt <= tcnt_n;
      tbit <= tbit_n;
      tsh <= tsh_n;
      txq <= txq_n;
    end
  end
  // txq is the registered line value for the state being entered
  always_comb begin
    ts_n = ts;
    tcnt_n = tcnt + CW'(1);
    tbit_n = tbit;
    tsh_n = tsh;
    txq_n = txq;
    pop = 1'b0;
    case (ts)
      TX_IDLE: begin
        tcnt_n = '0;
        if (!empty) begin
          pop = 1'b1;
          tsh_n = dout;
          txq_n = 1'b0;
          ts_n = TX_START;
        end
      end
      TX_START: if (tcnt == CW'(C-1)) begin
        tcnt_n = '0;
        tbit_n = '0;
        txq_n = tsh[0];
        ts_n = TX_DATA;
      end
      TX_DATA: if (tcnt == CW'(C-1)) begin
        tcnt_n = '0;
        if (tbit == BW'(DATA_W-1)) begin
          txq_n = 1'b1;
          ts_n = TX_STOP;
        end else begin
          tbit_n = tbit + BW'(1);
          tsh_n = tsh >> 1;
          txq_n = tsh[1];
        end
      end
      TX_STOP: if (tcnt == CW'(C-1)) begin
        tcnt_n = '0;
        ts_n = TX_IDLE;
      end
      default: ts_n = TX_IDLE;
    endcase
  end
  assign uart.tx = txq;
  assign uart.tx2 = echo;
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed checks of the UART loopback buffer at 32 clocks per bit plus a standalone FIFO
module tb_fifo_buffer;
  import fifo_buffer_pkg::*;
  localparam int C = 32;
  localparam int H = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_buffer_if u_if();
  fifo_buffer #(.CLK_FREQ(307200), .BAUD(9600), .DEPTH(32), .DATA_W(8)) dut (
    .clock(clk), .reset(rst), .uart(u_if)
  );
  logic sf_push = 1'b0, sf_pop = 1'b0, sf_full, sf_empty;
  logic [7:0] sf_din = 8'h00, sf_dout;
  sync_fifo #(.DATA_W(8), .DEPTH(32)) u_sf (
    .clk(clk), .rst(rst), .push(sf_push), .pop(sf_pop),
    .din(sf_din), .dout(sf_dout), .full(sf_full), .empty(sf_empty)
  );
  int pass_cnt = 0;
  int total = 0;
  logic [7:0] q[$];
  logic [7:0] mb;
  // tx frame monitor: samples each bit mid-period, keeps bytes with a valid stop bit
  initial begin
    forever begin
      @(negedge clk);
      if (u_if.tx === 1'b0 && !rst) begin
        repeat (H) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          mb[i] = u_if.tx;
        end
        repeat (C) @(negedge clk);
        if (u_if.tx === 1'b1) q.push_back(mb);
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, input int bp, input logic stop);
    @(negedge clk);
    u_if.rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      repeat (bp) @(negedge clk);
    end
    u_if.rx = stop;
    repeat (bp) @(negedge clk);
  endtask
  task automatic wait_q(input int n, input int lim);
    for (int i = 0; i < lim && q.size() < n; i++) @(negedge clk);
  endtask
  task automatic test_reset();
    int lows, pops;
    lows = 0;
    pops = 0;
    repeat (3) @(negedge clk);
    total++; if (u_if.tx !== 1'b1) $display("FAIL reset_tx_held: got %b, expected 1", u_if.tx); else pass_cnt++;
    total++; if (u_if.tx2 !== 1'b1) $display("FAIL reset_tx2_held: got %b, expected 1", u_if.tx2); else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (u_if.tx !== 1'b1) lows++;
      if (dut.pop !== 1'b0) pops++;
    end
    total++; if (lows != 0) $display("FAIL idle_tx: got %0d low cycles, expected 0", lows); else pass_cnt++;
    total++; if (pops != 0) $display("FAIL idle_pop: got %0d pops, expected 0", pops); else pass_cnt++;
    total++; if (u_if.tx2 !== 1'b1) $display("FAIL idle_tx2: got %b, expected 1", u_if.tx2); else pass_cnt++;
    total++; if (dut.u_fifo.empty !== 1'b1) $display("FAIL idle_empty: got %b, expected 1", dut.u_fifo.empty); else pass_cnt++;
    total++; if (dut.rs !== RX_IDLE || dut.ts !== TX_IDLE) $display("FAIL idle_fsm: got rx %0d tx %0d, expected 0 0", dut.rs, dut.ts); else pass_cnt++;
  endtask
  task automatic test_single();
    int lo1, hi1, lo2, lat, emis;
    logic h0, h1, h2;
    logic [7:0] got;
    lo1 = 0; hi1 = 0; lo2 = 0; lat = 0; emis = 0;
    h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
    q.delete();
    fork
      send_byte(8'h01, 33, 1'b1);
      begin
        for (int i = 0; i < 3000 && u_if.tx !== 1'b0; i++) @(negedge clk);
        while (u_if.tx === 1'b0 && lo1 < 1000) begin lo1++; @(negedge clk); end
        while (u_if.tx === 1'b1 && hi1 < 1000) begin hi1++; @(negedge clk); end
        while (u_if.tx === 1'b0 && lo2 < 1000) begin lo2++; @(negedge clk); end
      end
      begin
        for (int i = 0; i < 3000 && dut.push !== 1'b1; i++) @(negedge clk);
        while (u_if.tx !== 1'b0 && lat < 10) begin @(negedge clk); lat++; end
      end
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        #1;
        if (u_if.tx2 !== h2) emis++;
        {h2, h1, h0} = {h1, h0, u_if.rx};
      end
    join
    total++; if (lo1 != C) $display("FAIL single_start_len: got %0d, expected %0d", lo1, C); else pass_cnt++;
    total++; if (hi1 != C) $display("FAIL single_bit0_len: got %0d, expected %0d", hi1, C); else pass_cnt++;
    total++; if (lo2 != 7*C) $display("FAIL single_zero_run: got %0d, expected %0d", lo2, 7*C); else pass_cnt++;
    total++; if (lat < 2 || lat > 4) $display("FAIL single_latency: got %0d, expected 2..4", lat); else pass_cnt++;
    total++; if (emis != 0) $display("FAIL tx2_echo: got %0d mismatches, expected 0", emis); else pass_cnt++;
    wait_q(1, 500);
    got = (q.size() > 0) ? q[0] : 8'hxx;
    total++; if (q.size() != 1 || got !== 8'h01) $display("FAIL single_byte: got %0d bytes first %h, expected 1 byte 01", q.size(), got); else pass_cnt++;
  endtask
  task automatic test_sequence();
    int errs, bad;
    errs = 0;
    bad = -1;
    q.delete();
    for (int i = 1; i <= 32; i++) begin
      send_byte(8'(i), 33, 1'b1);
      repeat ((i == 25) ? 2000 : 20) @(negedge clk);
    end
    wait_q(32, 3000);
    total++; if (q.size() != 32) $display("FAIL seq_count: got %0d bytes, expected 32", q.size()); else pass_cnt++;
    foreach (q[i]) if (q[i] !== 8'(i + 1)) begin errs++; if (bad < 0) bad = i; end
    total++; if (errs != 0) $display("FAIL seq_order: got %0d wrong bytes (first at %0d), expected 0", errs, bad); else pass_cnt++;
  endtask
  task automatic test_overflow();
    int mx, errs;
    logic [7:0] exp;
    mx = 0;
    errs = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (int'(u_sf.count) > mx) mx = int'(u_sf.count);
      sf_push = 1'b1;
      sf_din = 8'(8'h40 + i);
    end
    @(negedge clk);
    sf_push = 1'b0;
    if (int'(u_sf.count) > mx) mx = int'(u_sf.count);
    total++; if (sf_full !== 1'b1 || u_sf.count !== 6'd32) $display("FAIL ovf_full: got full %b count %0d, expected 1 32", sf_full, u_sf.count); else pass_cnt++;
    total++; if (mx > 32) $display("FAIL ovf_max_count: got %0d, expected <= 32", mx); else pass_cnt++;
    total++; if (sf_dout !== 8'h40) $display("FAIL ovf_head: got %h, expected 40", sf_dout); else pass_cnt++;
    sf_push = 1'b1; sf_pop = 1'b1; sf_din = 8'hEE;
    @(negedge clk);
    sf_push = 1'b0; sf_pop = 1'b0;
    total++; if (u_sf.count !== 6'd32 || sf_dout !== 8'h41) $display("FAIL full_push_pop: got count %0d head %h, expected 32 41", u_sf.count, sf_dout); else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      exp = (i < 31) ? 8'(8'h41 + i) : 8'hEE;
      if (sf_dout !== exp) errs++;
      sf_pop = 1'b1;
      @(negedge clk);
    end
    sf_pop = 1'b0;
    total++; if (errs != 0) $display("FAIL ovf_drain_order: got %0d wrong bytes, expected 0", errs); else pass_cnt++;
    total++; if (sf_empty !== 1'b1 || u_sf.count !== 6'd0) $display("FAIL ovf_drained: got empty %b count %0d, expected 1 0", sf_empty, u_sf.count); else pass_cnt++;
    sf_pop = 1'b1;
    @(negedge clk);
    total++; if (u_sf.count !== 6'd0) $display("FAIL empty_pop: got count %0d, expected 0", u_sf.count); else pass_cnt++;
    sf_push = 1'b1; sf_din = 8'h77;
    @(negedge clk);
    sf_push = 1'b0; sf_pop = 1'b0;
    total++; if (u_sf.count !== 6'd1 || sf_dout !== 8'h77) $display("FAIL empty_push_pop: got count %0d head %h, expected 1 77", u_sf.count, sf_dout); else pass_cnt++;
  endtask
  task automatic test_glitch();
    q.delete();
    @(negedge clk);
    u_if.rx = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (dut.rs !== RX_START) $display("FAIL glitch_start: got %0d, expected %0d", dut.rs, RX_START); else pass_cnt++;
    u_if.rx = 1'b1;
    repeat (300) @(negedge clk);
    total++; if (dut.rs !== RX_IDLE) $display("FAIL glitch_idle: got %0d, expected %0d", dut.rs, RX_IDLE); else pass_cnt++;
    total++; if (dut.u_fifo.empty !== 1'b1 || q.size() != 0) $display("FAIL glitch_no_push: got empty %b tx bytes %0d, expected 1 0", dut.u_fifo.empty, q.size()); else pass_cnt++;
  endtask
  task automatic test_framing();
    int lows;
    logic [7:0] got;
    lows = 0;
    q.delete();
    send_byte(8'hA5, 32, 1'b0);
    u_if.rx = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (u_if.tx !== 1'b1) lows++;
    end
    total++; if (lows != 0 || dut.u_fifo.empty !== 1'b1) $display("FAIL frame_err_discard: got %0d tx low cycles empty %b, expected 0 1", lows, dut.u_fifo.empty); else pass_cnt++;
    total++; if (dut.rs !== RX_IDLE) $display("FAIL frame_err_idle: got %0d, expected %0d", dut.rs, RX_IDLE); else pass_cnt++;
    send_byte(8'h3C, 32, 1'b1);
    wait_q(1, 1000);
    got = (q.size() > 0) ? q[0] : 8'hxx;
    total++; if (q.size() != 1 || got !== 8'h3C) $display("FAIL frame_recover: got %0d bytes first %h, expected 1 byte 3c", q.size(), got); else pass_cnt++;
  endtask
  task automatic test_reset_midframe();
    logic [7:0] got;
    repeat (400) @(negedge clk);
    q.delete();
    send_byte(8'h55, 32, 1'b1);
    for (int i = 0; i < 200 && u_if.tx !== 1'b0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    total++; if (dut.ts === TX_IDLE) $display("FAIL midframe_busy: got %0d, expected non-idle", dut.ts); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++; if (u_if.tx !== 1'b1) $display("FAIL midframe_tx: got %b, expected 1", u_if.tx); else pass_cnt++;
    total++; if (dut.u_fifo.empty !== 1'b1 || dut.ts !== TX_IDLE) $display("FAIL midframe_clear: got empty %b tx state %0d, expected 1 0", dut.u_fifo.empty, dut.ts); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    q.delete();
    send_byte(8'h96, 32, 1'b1);
    wait_q(1, 1000);
    got = (q.size() > 0) ? q[0] : 8'hxx;
    total++; if (q.size() != 1 || got !== 8'h96) $display("FAIL midframe_resume: got %0d bytes first %h, expected 1 byte 96", q.size(), got); else pass_cnt++;
  endtask
  initial begin
    u_if.rx = 1'b1;
    test_reset();
    test_single();
    test_sequence();
    test_overflow();
    test_glitch();
    test_framing();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
UART loopback buffer that sits between a serial receive line and two serial transmit lines. It deserialises 8N1 bytes arriving on rx and stores them in a synchronous FIFO. Stored bytes are re-serialised in arrival order on tx. tx2 is a registered echo of the synchronised rx line, used for line monitoring.

Parameters:
- CLK_FREQ, 12_000_000: clock frequency in Hz (period ~83.3 ns).
- BAUD, 9600: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (1250): clocks per bit, integer division.
- DEPTH, 32: FIFO entries, power of two.
- DATA_W, 8: data bits per frame.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx     in  1  serial input, 8N1, LSB first, idle high, asynchronous to clock.
- tx     out 1  serial output, 8N1, LSB first, idle high.
- tx2    out 1  rx echo: rx after the 2-flop synchroniser plus one output register.

Behaviour:
- Reset: tx=1, tx2=1, FIFO empty, both pointers and the count at 0, RX and TX FSMs in IDLE, synchroniser flops set to 1.
  - Reset asserted mid-frame aborts the frame immediately and discards FIFO contents.
- rx synchroniser: 2 flops, reset value 1. All receive logic uses the synchronised signal.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE to START on a synchronised falling edge (1 to 0).
  - START: wait CLKS_PER_BIT/2 clocks, then resample. If the line is still 0, go to DATA; if 1, treat as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT clocks at mid-bit, shifting LSB first, 8 bits total, then go to STOP.
  - STOP: sample at mid-bit. If 1, push the byte (one-cycle push) and return to IDLE. If 0, it is a framing error: discard the byte and wait for the line to return to 1 before going to IDLE.
  - The receiver must tolerate ±2% baud mismatch; a 105 us bit period must decode correctly.
- FIFO:
  - Write when push and not full. A push while full drops the new byte; stored data is unchanged.
  - Read (pop) when the TX FSM requests and the FIFO is not empty.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
  - Simultaneous push and pop while full: the pop succeeds and the push is accepted, so the count is unchanged.
  - Simultaneous push and pop while empty: only the push takes effect.
- TX FSM, states IDLE, START, DATA, STOP:
  - In IDLE, when the FIFO is not empty: pop, latch the byte and go to START. tx drives 0 on the next clock.
  - START, then 8 data bits LSB first, then the stop bit (1), each held for CLKS_PER_BIT clocks.
  - After STOP return to IDLE. A back-to-back frame may start on the cycle after STOP ends.
  - Frame length is exactly 10*CLKS_PER_BIT clocks. Output is registered and glitch-free.
- Latency: tx falls 2 to 4 clocks after the push of the first byte into an empty FIFO, when TX is idle.
- Throughput: TX rate equals the nominal RX rate. Since the 105 us input bit period is slightly slower than the nominal 104.2 us output, the FIFO never overflows under continuous input.

Decomposition:
- Shared package: CLKS_PER_BIT computation, the DATA_W/DEPTH defaults, and the RX and TX state enumerations.
- One natural sub-module, sync_fifo (parameterised DATA_W/DEPTH; ports push, pop, din, dout, full, empty).
- UART RX and TX FSMs stay in the top level.

Test Plan:
- Reset released, rx idle for 1 ms -> tx=1, tx2=1, FIFO empty, no pop.
- Single byte 0x01 on rx at a 105 us bit period -> one frame on tx, LSB first: 0,1,0,0,0,0,0,0,0,1 at 1250 clocks per bit. tx2 mirrors rx with a 3-clock delay.
- Bytes 0x01..0x20 at ~10 ms spacing, including a 409 ms idle gap after 0x19 -> tx emits 0x01..0x20 in order with no loss and no duplicates.
- DEPTH+4 back-to-back frames with TX held busy by a forced burst -> bytes past full are dropped; the full flag is asserted and the count never exceeds 32.
- Start-bit glitch: rx low for 400 clocks -> no push, and RX returns to IDLE.
- Framing error (stop bit 0) on 0xA5 -> byte discarded, tx stays idle. A following valid 0x3C is received and transmitted.
- Reset asserted mid-frame on tx -> tx=1 immediately, FIFO empty. Operation resumes normally after reset is released.
